// File: rtl/msd_to_bin.sv
// rtl/msd_to_bin.sv - MSD digit vector to two's-complement binary converter
module msd_to_bin #(
    parameter int DIGITS = 77,
    parameter int CHUNK  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DIGITS-1:0]   in_digits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGITS:0]       out_data,
    output logic                  out_err
);

    // Number of chunk steps, padded mask width, counter and shift widths.
    localparam int NC = (DIGITS + CHUNK - 1) / CHUNK;
    localparam int PW = NC * CHUNK;
    localparam int KW = (NC > 1) ? $clog2(NC) : 1;
    localparam int SW = $clog2(PW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2*DIGITS-1:0] digits_q;
    logic [KW-1:0]       k;
    logic                borrow;
    logic                err;
    logic [DIGITS:0]     result;

    logic [PW-1:0]       p_pad;
    logic [PW-1:0]       n_pad;
    logic [PW-1:0]       ill_pad;
    logic [SW-1:0]       shamt;
    logic [CHUNK-1:0]    p_chunk;
    logic [CHUNK-1:0]    n_chunk;
    logic [CHUNK-1:0]    ill_chunk;
    logic [CHUNK:0]      diff;
    logic                borrow_out;
    logic [DIGITS-1:0]   wmask;
    logic [DIGITS-1:0]   wdata;
    logic                last;

    // Decode each registered digit into +1 / -1 / illegal masks; padding positions stay zero.
    always_comb begin
        p_pad   = '0;
        n_pad   = '0;
        ill_pad = '0;
        for (int i = 0; i < DIGITS; i++) begin
            p_pad[i]   = (digits_q[2*i +: 2] == 2'b11);
            n_pad[i]   = (digits_q[2*i +: 2] == 2'b01);
            ill_pad[i] = (digits_q[2*i +: 2] == 2'b00);
        end
    end

    // Select the current chunk and perform the borrow-propagating subtract P - N - borrow.
    always_comb begin
        shamt      = SW'(k) * SW'(CHUNK);
        p_chunk    = p_pad[shamt +: CHUNK];
        n_chunk    = n_pad[shamt +: CHUNK];
        ill_chunk  = ill_pad[shamt +: CHUNK];
        diff       = {1'b0, p_chunk} - {1'b0, n_chunk} - {{CHUNK{1'b0}}, borrow};
        borrow_out = diff[CHUNK];
        // Bits shifted past DIGITS fall off, which clips the last chunk to the vector width.
        wmask      = DIGITS'({CHUNK{1'b1}}) << shamt;
        wdata      = DIGITS'(diff[CHUNK-1:0]) << shamt;
        last       = (k == KW'(NC - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, walk NC chunks, then hold the result until taken.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = CONV;
            CONV:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: capture the vector on accept, then fill the result one chunk per cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            digits_q <= '0;
            k        <= '0;
            borrow   <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        digits_q <= in_digits;
                        k        <= '0;
                        borrow   <= 1'b0;
                        err      <= 1'b0;
                        result   <= '0;
                    end
                end
                CONV: begin
                    result[DIGITS-1:0] <= (result[DIGITS-1:0] & ~wmask) | wdata;
                    borrow             <= borrow_out;
                    err                <= err | (|ill_chunk);
                    if (last) begin
                        // The final borrow out is the sign of P - N.
                        result[DIGITS] <= borrow_out;
                        k              <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = result;
    assign out_err  = err;

endmodule

// File: tb/tb_msd_to_bin.sv
// tb/tb_msd_to_bin.sv - self-checking bench for msd_to_bin
module tb_msd_to_bin;

    localparam int DIGITS = 77;
    localparam int CHUNK  = 8;
    localparam int NC     = (DIGITS + CHUNK - 1) / CHUNK;

    typedef logic [2*DIGITS-1:0] vec_t;
    typedef logic [DIGITS:0]     val_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    vec_t in_digits;
    logic out_valid;
    logic out_ready;
    val_t out_data;
    logic out_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    msd_to_bin #(.DIGITS(DIGITS), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digits (in_digits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: value = sum of d_i * 2^i in DIGITS+1 bit two's complement.
    function automatic void model(input vec_t v, output val_t val, output logic e);
        val = '0;
        e   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            case (v[2*i +: 2])
                2'b11:   val = val + (val_t'(1) << i);
                2'b01:   val = val - (val_t'(1) << i);
                2'b00:   e = 1'b1;
                default: ;
            endcase
        end
    endfunction

    function automatic vec_t fill(input logic [1:0] c);
        vec_t v;
        for (int i = 0; i < DIGITS; i++) v[2*i +: 2] = c;
        return v;
    endfunction

    function automatic vec_t rand_vec(input bit allow_ill);
        vec_t v;
        logic [1:0] c;
        for (int i = 0; i < DIGITS; i++) begin
            case ($urandom_range(0, 2))
                0:       c = 2'b10;
                1:       c = 2'b11;
                default: c = 2'b01;
            endcase
            if (allow_ill && ($urandom_range(0, 24) == 0)) c = 2'b00;
            v[2*i +: 2] = c;
        end
        return v;
    endfunction

    // Drives one vector, waits for the result and takes it; lat = clock edges after the accept edge.
    task automatic convert(input vec_t v, output val_t d, output logic e, output int lat, output bit ok);
        int g;
        ok  = 1'b1;
        lat = 0;
        d   = '0;
        e   = 1'b0;
        @(negedge clk);
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            return;
        end
        in_digits = v;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        d = out_data;
        e = out_err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        checks++;
        if (out_data !== val_t'(0) || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h err=%b expected 0 0", out_data, out_err);
        end
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        val_t d; logic e; int lat; bit ok;
        convert(fill(2'b10), d, e, lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL zero_timeout: no result within bound");
            return;
        end
        checks++;
        if (lat !== NC) begin
            errors++;
            $display("FAIL zero_latency: got %0d edges expected %0d", lat, NC);
        end
        checks++;
        if (d !== val_t'(0) || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_value: data=%h err=%b expected 0 0", d, e);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_return_idle: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        vec_t vecs[5];
        val_t exp[5];
        val_t d; logic e; int lat; bit ok;
        vecs[0] = fill(2'b10); vecs[0][1:0] = 2'b11;
        exp[0]  = val_t'(1);
        vecs[1] = fill(2'b10); vecs[1][1:0] = 2'b01;
        exp[1]  = '1;
        vecs[2] = fill(2'b01); vecs[2][2*(DIGITS-1) +: 2] = 2'b11;
        exp[2]  = val_t'(1);
        vecs[3] = fill(2'b01);
        exp[3]  = {1'b1, {(DIGITS-1){1'b0}}, 1'b1};
        vecs[4] = fill(2'b11);
        exp[4]  = {1'b0, {DIGITS{1'b1}}};
        for (int j = 0; j < 5; j++) begin
            convert(vecs[j], d, e, lat, ok);
            checks++;
            if (!ok || d !== exp[j] || e !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d: ok=%b data=%h err=%b expected data=%h err=0", j, ok, d, e, exp[j]);
            end
        end
    endtask

    task automatic test_illegal();
        vec_t v; val_t d; logic e; int lat; bit ok;
        v = fill(2'b10);
        v[1:0] = 2'b11;
        v[7:6] = 2'b00;
        convert(v, d, e, lat, ok);
        checks++;
        if (!ok || d !== val_t'(1) || e !== 1'b1) begin
            errors++;
            $display("FAIL illegal_digit: ok=%b data=%h err=%b expected data=1 err=1", ok, d, e);
        end
        v = fill(2'b10);
        v[2*(DIGITS-1) +: 2] = 2'b00;
        convert(v, d, e, lat, ok);
        checks++;
        if (!ok || d !== val_t'(0) || e !== 1'b1) begin
            errors++;
            $display("FAIL illegal_top_digit: ok=%b data=%h err=%b expected data=0 err=1", ok, d, e);
        end
    endtask

    task automatic test_backpressure();
        vec_t v; val_t exp_d; logic exp_e; int g; bit bad;
        v = rand_vec(1'b0);
        v[2*10 +: 2] = 2'b00;
        model(v, exp_d, exp_e);
        @(negedge clk);
        in_digits = v;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL bp_timeout: no out_valid within bound");
            return;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_digits = fill(2'b11);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d || out_err !== exp_e) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b ready=%b data=%h err=%b expected 1 0 %h %b",
                         i, out_valid, in_ready, out_data, out_err, exp_d, exp_e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        bad = 1'b0;
        for (int i = 0; i < NC + 3; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_pulse_ignored: block left idle after the blocked in_valid pulse, got 1 expected 0");
        end
    endtask

    task automatic test_reset_mid_conv();
        vec_t v; val_t d; logic e; int lat; bit ok;
        v = fill(2'b10);
        v[1:0] = 2'b11;
        v[7:6] = 2'b00;
        @(negedge clk);
        in_digits = v;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== val_t'(0) || out_err !== 1'b0) begin
            errors++;
            $display("FAIL midconv_reset: ready=%b valid=%b data=%h err=%b expected 1 0 0 0",
                     in_ready, out_valid, out_data, out_err);
        end
        rst_n = 1'b0;
        convert(fill(2'b10), d, e, lat, ok);
        checks++;
        if (!ok || lat !== NC || d !== val_t'(0) || e !== 1'b0) begin
            errors++;
            $display("FAIL midconv_after: ok=%b lat=%0d data=%h err=%b expected 1 %0d 0 0", ok, lat, d, e, NC);
        end
    endtask

    task automatic test_random();
        vec_t v; val_t d, exp_d; logic e, exp_e; int lat; bit ok;
        for (int j = 0; j < 24; j++) begin
            v = rand_vec(j[0]);
            model(v, exp_d, exp_e);
            convert(v, d, e, lat, ok);
            checks++;
            if (!ok || d !== exp_d || e !== exp_e || lat !== NC) begin
                errors++;
                $display("FAIL random_%0d: ok=%b lat=%0d data=%h err=%b expected data=%h err=%b",
                         j, ok, lat, d, e, exp_d, exp_e);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v; val_t exp_d; logic exp_e; int g; int t_prev; int t_now;
        t_prev    = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            v = rand_vec(1'b1);
            model(v, exp_d, exp_e);
            g = 0;
            while (!in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            t_now = cyc;
            if (j > 0) begin
                checks++;
                if (!in_ready || (t_now - t_prev) !== NC + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d cycles expected %0d", j, t_now - t_prev, NC + 2);
                end
            end
            t_prev    = t_now;
            in_digits = v;
            @(negedge clk);
            g = 0;
            while (!out_valid && g < 200) begin
                @(negedge clk);
                g++;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_err !== exp_e) begin
                errors++;
                $display("FAIL b2b_value_%0d: valid=%b data=%h err=%b expected 1 %h %b",
                         j, out_valid, out_data, out_err, exp_d, exp_e);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_digits = '0;
        out_ready = 1'b0;
        test_reset();
        test_zero();
        test_directed();
        test_illegal();
        test_backpressure();
        test_reset_mid_conv();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msd_to_bin.md
Name: msd_to_bin

Overview:
- Converts one MSD (modified signed-digit, four-valued 2-bit-per-digit) product vector into a two's-complement binary integer.
- Sits at the output of the MSD multiplier datapath and feeds binary consumers.
- Processes CHUNK digits per cycle, LSB chunk first, using a borrow-propagating subtract of the positive and negative digit masks.
- Uses valid/ready handshakes on both sides.

Parameters:
- DIGITS, 77, number of MSD digits in the input vector (multiplier result width / 2).
- CHUNK, 8, digits converted per cycle.

Ports:
- clk  input  1  clock. One clock domain.
- rst_n  input  1  reset. Synchronous and active-high; port name kept per codebase convention.
- in_valid  input  1  in_digits valid.
- in_ready  output  1  block can accept a vector.
- in_digits  input  2*DIGITS  MSD vector. Digit i is in_digits[2i+1:2i]; digit 0 has weight 2^0.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  DIGITS+1  two's-complement value, sum of d_i*2^i.
- out_err  output  1  at least one illegal digit code was present.

Behaviour:
- Digit encoding:
  - 2'b10 = 0.
  - 2'b11 = +1.
  - 2'b01 = −1.
  - 2'b00 = illegal: treated as 0 and sets out_err.
- Derived masks: P[i] = (digit i == +1), N[i] = (digit i == −1). Result = P − N.
- Chunk count: NC = ceil(DIGITS/CHUNK). Digit positions ≥ DIGITS in the last chunk are zero-padded.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready, register in_digits, clear borrow, clear chunk counter k, clear err accumulator, go to CONV.
  - CONV: in_ready=0. Each cycle compute {b', r} = P[k-chunk] − N[k-chunk] − borrow (CHUNK-bit subtract, b' = borrow out). Write r into result bits [k*CHUNK +: CHUNK], clipped to DIGITS. borrow ← b'. OR that chunk's illegal flags into err. k++. When k == NC−1 is processed, write result bit DIGITS = final borrow (sign) and go to DONE.
  - DONE: out_valid=1, in_ready=0. out_data and out_err are held stable. On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: accept at cycle T; CONV occupies T+1..T+NC; out_valid first high at T+NC+1 (11 cycles for defaults).
- Throughput: one vector per NC+2 cycles with out_ready tied high. There is no overlap of accept and output.
- in_valid while in_ready=0 is ignored. in_digits is only sampled at accept.
- out_data is written progressively inside CONV. It is only defined while out_valid=1.
- Range: the result always fits DIGITS+1 bits, because |P−N| ≤ 2^DIGITS − 1, so there is no overflow case.
- Reset (any state, including mid-CONV or DONE): next cycle state=IDLE, in_ready=1, out_valid=0, out_err=0, out_data=0, borrow=0, k=0. Any in-flight conversion is discarded.
- Reset has priority over an in_valid/out_ready handshake in the same cycle.

Test Plan:
- All digits 2'b10, accept at T → out_valid rises at T+11; out_data=0; out_err=0; in_ready returns high the cycle after out_ready.
- Digit0=2'b11, rest 2'b10 → out_data=1. Digit0=2'b01, rest 2'b10 → out_data=78'h3FFF…F (−1).
- Digit76=+1, digits 0..75=−1 → out_data=1. This exercises borrow across all 10 chunks.
- All digits −1 → out_data = −(2^77−1) = {1'b1, 76'b0, 1'b1}. All digits +1 → out_data = 2^77−1 (bit 77=0, rest 1).
- Backpressure: out_ready low for 5 cycles after out_valid → out_data/out_err stable; in_ready=0; a concurrent in_valid pulse is not accepted; the result transfers on the first out_ready cycle.
- Digit0=+1, digit3=2'b00 → out_data=1, out_err=1.
- Reset asserted on the 4th CONV cycle → the next cycle shows in_ready=1, out_valid=0; a new all-zero vector then completes normally with out_err=0.
